fpu_wb_ctrl: RTL and testbench

Writeback and status stage directly downstream of the half-precision FPU execution unit. Tracks the destination of every dispatched FPU op in a small tag queue and pairs it with the unit's registered one-cycle result. Routes the result to the FP register file or, through a back-pressured handshake, to the integer register file. Owns the fcsr (frm plus sticky fflags) and an FPR busy scoreboard used by issue for hazard checks.

---
 rtl/fpu_wb_ctrl_if.sv | 22 ++
 rtl/fpu_wb_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_fpu_wb_ctrl.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_wb_ctrl_if.sv
// fpu_wb_ctrl_if: GPR writeback valid/ready port.
// The master holds valid, address and data until ready.
interface fpu_wb_ctrl_if;
  logic        gpr_wr_valid;
  logic        gpr_wr_ready;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;

  modport master (
    output gpr_wr_valid,
    output gpr_waddr,
    output gpr_wdata,
    input  gpr_wr_ready
  );

  modport slave (
    input  gpr_wr_valid,
    input  gpr_waddr,
    input  gpr_wdata,
    output gpr_wr_ready
  );
endinterface

// File: rtl/fpu_wb_ctrl.sv
// fpu_wb_ctrl: FPU writeback, fcsr and FPR busy scoreboard.
// Completions pair with queued tags; GPR results are buffered.
module fpu_wb_ctrl #(
  parameter int FPLEN      = 16,
  parameter int TAGQ_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             disp_valid,
  input  logic [4:0]       disp_rd,
  input  logic             disp_rd_fp,
  output logic             disp_ready,
  input  logic             fpu_complete,
  input  logic [FPLEN-1:0] fpu_result_1,
  input  logic [31:0]      fpu_result_rd,
  input  logic [4:0]       sflags,
  output logic             fpr_we,
  output logic [4:0]       fpr_waddr,
  output logic [FPLEN-1:0] fpr_wdata,
  fpu_wb_ctrl_if.master    gpr,
  input  logic             csr_we,
  input  logic [7:0]       csr_wdata,
  output logic [7:0]       fcsr,
  output logic [2:0]       fpu_rnd,
  output logic [31:0]      fpr_busy,
  output logic             err_orphan
);

  localparam int CW = $clog2(TAGQ_DEPTH + 1);
  localparam int IW = (TAGQ_DEPTH > 1) ?
                      $clog2(TAGQ_DEPTH) : 1;

  typedef enum logic [1:0] {
    GB_EMPTY,
    GB_ONE,
    GB_TWO
  } gb_state_e;

  logic [TAGQ_DEPTH-1:0][4:0] tq_rd_q, tq_rd_d;
  logic [TAGQ_DEPTH-1:0]      tq_fp_q, tq_fp_d;
  logic [CW-1:0]              tq_cnt_q, tq_cnt_d;
  logic                       tq_push, tq_pop;
  logic [IW-1:0]              tq_widx;

  gb_state_e   gb_state_q, gb_state_d;
  logic [4:0]  gb0_rd_q, gb0_rd_d;
  logic [4:0]  gb1_rd_q, gb1_rd_d;
  logic [31:0] gb0_dat_q, gb0_dat_d;
  logic [31:0] gb1_dat_q, gb1_dat_d;
  logic        gb_push, gb_acc;
  logic [1:0]  gb_cnt;

  logic             fpr_we_q, fpr_we_d;
  logic [4:0]       fpr_waddr_q, fpr_waddr_d;
  logic [FPLEN-1:0] fpr_wdata_q, fpr_wdata_d;
  logic [31:0]      busy_q, busy_d;
  logic [31:0]      busy_set, busy_clr, busy_pend;

  logic       flag_pend_q, flag_pend_d;
  logic [2:0] frm_q, frm_d;
  logic [4:0] ff_q, ff_d;
  logic       err_q, err_d;

  assign disp_ready = (32'(tq_cnt_q) + 32'(gb_cnt))
                      < 32'(TAGQ_DEPTH);

  always_comb begin
    tq_push  = disp_valid & disp_ready;
    tq_pop   = fpu_complete & (tq_cnt_q != '0);
    tq_rd_d  = tq_rd_q;
    tq_fp_d  = tq_fp_q;
    tq_widx  = IW'(tq_cnt_q - CW'(tq_pop));
    if (tq_pop) begin
      for (int i = 0; i < TAGQ_DEPTH - 1; i++) begin
        tq_rd_d[i] = tq_rd_q[i+1];
        tq_fp_d[i] = tq_fp_q[i+1];
      end
    end
    if (tq_push) begin
      tq_rd_d[tq_widx] = disp_rd;
      tq_fp_d[tq_widx] = disp_rd_fp;
    end
    tq_cnt_d = tq_cnt_q + CW'(tq_push) - CW'(tq_pop);
  end

  always_comb begin
    gb_push    = tq_pop & ~tq_fp_q[0];
    gb_acc     = (gb_state_q != GB_EMPTY) &
                 gpr.gpr_wr_ready;
    gb_state_d = gb_state_q;
    gb0_rd_d   = gb0_rd_q;
    gb0_dat_d  = gb0_dat_q;
    gb1_rd_d   = gb1_rd_q;
    gb1_dat_d  = gb1_dat_q;
    gb_cnt     = 2'd0;
    unique case (gb_state_q)
      GB_EMPTY: begin
        if (gb_push) begin
          gb_state_d = GB_ONE;
          gb0_rd_d   = tq_rd_q[0];
          gb0_dat_d  = fpu_result_rd;
        end
      end
      GB_ONE: begin
        gb_cnt = 2'd1;
        if (gb_push && gb_acc) begin
          gb0_rd_d  = tq_rd_q[0];
          gb0_dat_d = fpu_result_rd;
        end else if (gb_push) begin
          gb_state_d = GB_TWO;
          gb1_rd_d   = tq_rd_q[0];
          gb1_dat_d  = fpu_result_rd;
        end else if (gb_acc) begin
          gb_state_d = GB_EMPTY;
        end
      end
      GB_TWO: begin
        gb_cnt = 2'd2;
        // a push here only ever coincides with an accept
        if (gb_acc) begin
          gb0_rd_d  = gb1_rd_q;
          gb0_dat_d = gb1_dat_q;
          if (gb_push) begin
            gb1_rd_d  = tq_rd_q[0];
            gb1_dat_d = fpu_result_rd;
          end else begin
            gb_state_d = GB_ONE;
          end
        end
      end
      default: gb_state_d = GB_EMPTY;
    endcase
  end

  assign gpr.gpr_wr_valid = gb_state_q != GB_EMPTY;
  assign gpr.gpr_waddr    = gb0_rd_q;
  assign gpr.gpr_wdata    = gb0_dat_q;

  always_comb begin
    fpr_we_d    = tq_pop & tq_fp_q[0];
    fpr_waddr_d = fpr_waddr_q;
    fpr_wdata_d = fpr_wdata_q;
    if (fpr_we_d) begin
      fpr_waddr_d = tq_rd_q[0];
      fpr_wdata_d = fpu_result_1;
    end
    // a newer queued op to the same FPR keeps its bit set
    busy_pend = '0;
    for (int j = 0; j < TAGQ_DEPTH; j++) begin
      if (j < int'(tq_cnt_q) && tq_fp_q[j]) begin
        busy_pend[tq_rd_q[j]] = 1'b1;
      end
    end
    busy_set = (tq_push & disp_rd_fp) ?
               (32'd1 << disp_rd) : '0;
    busy_clr = fpr_we_q ?
               ((32'd1 << fpr_waddr_q) & ~busy_pend) : '0;
    busy_d   = (busy_q & ~busy_clr) | busy_set;
  end

  always_comb begin
    flag_pend_d = fpu_complete;
    frm_d       = frm_q;
    ff_d        = ff_q;
    if (flag_pend_q) begin
      ff_d = ff_q | sflags;
    end
    if (csr_we) begin
      frm_d = csr_wdata[7:5];
      ff_d  = csr_wdata[4:0] |
              (flag_pend_q ? sflags : 5'd0);
    end
    err_d = err_q | (fpu_complete & (tq_cnt_q == '0));
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      tq_rd_q     <= '0;
      tq_fp_q     <= '0;
      tq_cnt_q    <= '0;
      gb_state_q  <= GB_EMPTY;
      gb0_rd_q    <= '0;
      gb0_dat_q   <= '0;
      gb1_rd_q    <= '0;
      gb1_dat_q   <= '0;
      fpr_we_q    <= 1'b0;
      fpr_waddr_q <= '0;
      fpr_wdata_q <= '0;
      busy_q      <= '0;
      flag_pend_q <= 1'b0;
      frm_q       <= '0;
      ff_q        <= '0;
      err_q       <= 1'b0;
    end else begin
      tq_rd_q     <= tq_rd_d;
      tq_fp_q     <= tq_fp_d;
      tq_cnt_q    <= tq_cnt_d;
      gb_state_q  <= gb_state_d;
      gb0_rd_q    <= gb0_rd_d;
      gb0_dat_q   <= gb0_dat_d;
      gb1_rd_q    <= gb1_rd_d;
      gb1_dat_q   <= gb1_dat_d;
      fpr_we_q    <= fpr_we_d;
      fpr_waddr_q <= fpr_waddr_d;
      fpr_wdata_q <= fpr_wdata_d;
      busy_q      <= busy_d;
      flag_pend_q <= flag_pend_d;
      frm_q       <= frm_d;
      ff_q        <= ff_d;
      err_q       <= err_d;
    end
  end

  assign fpr_we     = fpr_we_q;
  assign fpr_waddr  = fpr_waddr_q;
  assign fpr_wdata  = fpr_wdata_q;
  assign fpr_busy   = busy_q;
  assign fcsr       = {frm_q, ff_q};
  assign fpu_rnd    = frm_q;
  assign err_orphan = err_q;

endmodule

// File: tb/tb_fpu_wb_ctrl.sv
// tb_fpu_wb_ctrl: vector table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_fpu_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        disp_valid;
  logic [4:0]  disp_rd;
  logic        disp_rd_fp;
  logic        disp_ready;
  logic        fpu_complete;
  logic [15:0] fpu_result_1;
  logic [31:0] fpu_result_rd;
  logic [4:0]  sflags;
  logic        fpr_we;
  logic [4:0]  fpr_waddr;
  logic [15:0] fpr_wdata;
  logic        csr_we;
  logic [7:0]  csr_wdata;
  logic [7:0]  fcsr;
  logic [2:0]  fpu_rnd;
  logic [31:0] fpr_busy;
  logic        err_orphan;

  fpu_wb_ctrl_if gif ();

  always #5 clk = ~clk;

  fpu_wb_ctrl #(
    .FPLEN      (16),
    .TAGQ_DEPTH (2)
  ) dut (
    .clk           (clk),
    .rst_l         (rst_l),
    .disp_valid    (disp_valid),
    .disp_rd       (disp_rd),
    .disp_rd_fp    (disp_rd_fp),
    .disp_ready    (disp_ready),
    .fpu_complete  (fpu_complete),
    .fpu_result_1  (fpu_result_1),
    .fpu_result_rd (fpu_result_rd),
    .sflags        (sflags),
    .fpr_we        (fpr_we),
    .fpr_waddr     (fpr_waddr),
    .fpr_wdata     (fpr_wdata),
    .gpr           (gif),
    .csr_we        (csr_we),
    .csr_wdata     (csr_wdata),
    .fcsr          (fcsr),
    .fpu_rnd       (fpu_rnd),
    .fpr_busy      (fpr_busy),
    .err_orphan    (err_orphan)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic idle();
    disp_valid    = 1'b0;
    disp_rd       = '0;
    disp_rd_fp    = 1'b0;
    fpu_complete  = 1'b0;
    fpu_result_1  = '0;
    fpu_result_rd = '0;
    sflags        = '0;
    csr_we        = 1'b0;
    csr_wdata     = '0;
  endtask

  typedef struct {
    logic [4:0]  rd;
    logic        fp;
    logic [15:0] r1;
    logic [31:0] rr;
    logic [4:0]  sf;
    logic        exp_fwe;
    logic        exp_gv;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic [4:0]  exp_ff;
  } vec_t;

  vec_t vecs[5];

  typedef struct packed {
    logic [4:0] rd;
    logic       fp;
  } tag_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] d;
  } gw_t;

  tag_t        mtq[$];
  gw_t         mgq[$];
  int          bcnt[32];
  logic        m_we;
  logic [4:0]  m_wa;
  logic [15:0] m_wd;
  logic [4:0]  m_ff;
  logic [2:0]  m_frm;
  logic        m_pend;
  logic        m_err;
  logic        prev_acc;
  logic        exp_rdy;
  logic        acc;
  logic [31:0] eb;
  logic [31:0] act_d;
  logic [4:0]  act_a;
  tag_t        t;

  initial begin
    vecs[0] = '{5'd5, 1'b1, 16'h3C00, 32'h0, 5'b00001,
                1'b1, 1'b0, 5'd5, 32'h3C00, 5'b00001};
    vecs[1] = '{5'd3, 1'b0, 16'h0, 32'h1234_5678, 5'b00100,
                1'b0, 1'b1, 5'd3, 32'h1234_5678, 5'b00101};
    vecs[2] = '{5'd31, 1'b1, 16'h7BFF, 32'h0, 5'b00000,
                1'b1, 1'b0, 5'd31, 32'h7BFF, 5'b00101};
    vecs[3] = '{5'd0, 1'b0, 16'h0, 32'hFFFF_FFFF, 5'b10000,
                1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'b10101};
    vecs[4] = '{5'd0, 1'b1, 16'h0001, 32'h0, 5'b01010,
                1'b1, 1'b0, 5'd0, 32'h0001, 5'b11111};

    idle();
    rst_l = 1'b0;
    gif.gpr_wr_ready = 1'b0;
    #1;
    chk("rst_fcsr", 32'(fcsr), 0);
    chk("rst_rnd", 32'(fpu_rnd), 0);
    chk("rst_busy", fpr_busy, 0);
    chk("rst_fpr_we", 32'(fpr_we), 0);
    chk("rst_gpr_v", 32'(gif.gpr_wr_valid), 0);
    chk("rst_gpr_a", 32'(gif.gpr_waddr), 0);
    chk("rst_err", 32'(err_orphan), 0);
    chk("rst_ready", 32'(disp_ready), 1);
    @(negedge clk);
    @(negedge clk);
    rst_l = 1'b1;
    gif.gpr_wr_ready = 1'b1;

    // single-op vectors
    foreach (vecs[k]) begin
      @(negedge clk);
      chk("tbl_ready", 32'(disp_ready), 1);
      disp_valid = 1'b1;
      disp_rd    = vecs[k].rd;
      disp_rd_fp = vecs[k].fp;
      @(negedge clk);
      chk("tbl_busy_n1", 32'(fpr_busy[vecs[k].rd]),
          32'(vecs[k].fp));
      idle();
      fpu_complete  = 1'b1;
      fpu_result_1  = vecs[k].r1;
      fpu_result_rd = vecs[k].rr;
      @(negedge clk);
      chk("tbl_fpr_we", 32'(fpr_we), 32'(vecs[k].exp_fwe));
      chk("tbl_gpr_v", 32'(gif.gpr_wr_valid),
          32'(vecs[k].exp_gv));
      act_a = vecs[k].fp ? fpr_waddr : gif.gpr_waddr;
      act_d = vecs[k].fp ? 32'(fpr_wdata) : gif.gpr_wdata;
      chk("tbl_addr", 32'(act_a), 32'(vecs[k].exp_addr));
      chk("tbl_data", act_d, vecs[k].exp_data);
      chk("tbl_busy_n2", 32'(fpr_busy[vecs[k].rd]),
          32'(vecs[k].fp));
      idle();
      sflags = vecs[k].sf;
      @(negedge clk);
      chk("tbl_fflags", 32'(fcsr[4:0]), 32'(vecs[k].exp_ff));
      chk("tbl_we_off", 32'(fpr_we), 0);
      chk("tbl_gv_off", 32'(gif.gpr_wr_valid), 0);
      chk("tbl_busy_n3", 32'(fpr_busy[vecs[k].rd]), 0);
      idle();
    end

    // GPR back-pressure
    gif.gpr_wr_ready = 1'b0;
    disp_valid = 1'b1;
    disp_rd    = 5'd3;
    @(negedge clk);
    chk("stall_rdy1", 32'(disp_ready), 1);
    disp_rd       = 5'd4;
    fpu_complete  = 1'b1;
    fpu_result_rd = 32'd1;
    @(negedge clk);
    chk("stall_rdy", 32'(disp_ready), 0);
    chk("stall_v", 32'(gif.gpr_wr_valid), 1);
    chk("stall_a", 32'(gif.gpr_waddr), 3);
    chk("stall_d", gif.gpr_wdata, 1);
    idle();
    fpu_complete  = 1'b1;
    fpu_result_rd = 32'd2;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      idle();
      chk("stall_rdy", 32'(disp_ready), 0);
      chk("stall_v", 32'(gif.gpr_wr_valid), 1);
      chk("stall_a", 32'(gif.gpr_waddr), 3);
      chk("stall_d", gif.gpr_wdata, 1);
    end
    gif.gpr_wr_ready = 1'b1;
    @(negedge clk);
    chk("drain_v", 32'(gif.gpr_wr_valid), 1);
    chk("drain_a", 32'(gif.gpr_waddr), 4);
    chk("drain_d", gif.gpr_wdata, 2);
    @(negedge clk);
    chk("drain_empty", 32'(gif.gpr_wr_valid), 0);
    chk("drain_rdy", 32'(disp_ready), 1);

    // CSR write colliding with pending flags
    csr_we    = 1'b1;
    csr_wdata = 8'b000_00100;
    @(negedge clk);
    chk("csr_set", 32'(fcsr), 32'h04);
    idle();
    disp_valid = 1'b1;
    disp_rd    = 5'd9;
    disp_rd_fp = 1'b1;
    @(negedge clk);
    idle();
    fpu_complete = 1'b1;
    @(negedge clk);
    idle();
    csr_we    = 1'b1;
    csr_wdata = 8'b011_00000;
    sflags    = 5'b00010;
    @(negedge clk);
    chk("csr_coll", 32'(fcsr), 32'b011_00010);
    chk("csr_rnd", 32'(fpu_rnd), 3);
    idle();

    // scoreboard set/clear on same FPR
    disp_valid = 1'b1;
    disp_rd    = 5'd7;
    disp_rd_fp = 1'b1;
    @(negedge clk);
    chk("sb_rdy", 32'(disp_ready), 1);
    fpu_complete = 1'b1;
    fpu_result_1 = 16'hAAAA;
    @(negedge clk);
    chk("sb_we1", 32'(fpr_we), 1);
    chk("sb_d1", 32'(fpr_wdata), 32'hAAAA);
    chk("sb_busy1", 32'(fpr_busy[7]), 1);
    idle();
    fpu_complete = 1'b1;
    fpu_result_1 = 16'hBBBB;
    @(negedge clk);
    chk("sb_busy2", 32'(fpr_busy[7]), 1);
    chk("sb_d2", 32'(fpr_wdata), 32'hBBBB);
    idle();
    @(negedge clk);
    chk("sb_busy3", 32'(fpr_busy[7]), 0);
    chk("sb_we3", 32'(fpr_we), 0);

    // orphan completion
    fpu_complete = 1'b1;
    @(negedge clk);
    chk("orph_we", 32'(fpr_we), 0);
    chk("orph_gv", 32'(gif.gpr_wr_valid), 0);
    chk("orph_err", 32'(err_orphan), 1);
    idle();
    sflags = 5'b01000;
    @(negedge clk);
    chk("orph_flags", 32'(fcsr), 32'b011_01010);
    idle();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("orph_sticky", 32'(err_orphan), 1);
    end

    // reset with work in flight
    gif.gpr_wr_ready = 1'b0;
    disp_valid = 1'b1;
    disp_rd    = 5'd10;
    @(negedge clk);
    disp_rd       = 5'd11;
    fpu_complete  = 1'b1;
    fpu_result_rd = 32'hAA;
    @(negedge clk);
    idle();
    chk("mid_gv", 32'(gif.gpr_wr_valid), 1);
    rst_l = 1'b0;
    #1;
    chk("mid_gv0", 32'(gif.gpr_wr_valid), 0);
    chk("mid_ga0", 32'(gif.gpr_waddr), 0);
    chk("mid_gd0", gif.gpr_wdata, 0);
    chk("mid_we0", 32'(fpr_we), 0);
    chk("mid_fcsr0", 32'(fcsr), 0);
    chk("mid_err0", 32'(err_orphan), 0);
    chk("mid_busy0", fpr_busy, 0);
    chk("mid_rdy", 32'(disp_ready), 1);
    @(negedge clk);
    rst_l  = 1'b1;
    sflags = 5'b11111;
    gif.gpr_wr_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      sflags = '0;
      chk("post_we", 32'(fpr_we), 0);
      chk("post_gv", 32'(gif.gpr_wr_valid), 0);
      chk("post_rdy", 32'(disp_ready), 1);
      chk("post_fcsr", 32'(fcsr), 0);
    end

    // randomized run against the reference model
    mtq.delete();
    mgq.delete();
    foreach (bcnt[i]) bcnt[i] = 0;
    m_we = 0; m_wa = 0; m_wd = 0;
    m_ff = 0; m_frm = 0; m_pend = 0;
    m_err = 0; prev_acc = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      exp_rdy = (mtq.size() + mgq.size()) < 2;
      chk("r_ready", 32'(disp_ready), 32'(exp_rdy));
      chk("r_fpr_we", 32'(fpr_we), 32'(m_we));
      if (m_we) begin
        chk("r_fpr_a", 32'(fpr_waddr), 32'(m_wa));
        chk("r_fpr_d", 32'(fpr_wdata), 32'(m_wd));
      end
      chk("r_gpr_v", 32'(gif.gpr_wr_valid),
          32'(mgq.size() != 0));
      if (mgq.size() != 0) begin
        chk("r_gpr_a", 32'(gif.gpr_waddr), 32'(mgq[0].rd));
        chk("r_gpr_d", gif.gpr_wdata, mgq[0].d);
      end
      chk("r_fcsr", 32'(fcsr), 32'({m_frm, m_ff}));
      for (int i = 0; i < 32; i++) eb[i] = bcnt[i] > 0;
      chk("r_busy", fpr_busy, eb);
      chk("r_err", 32'(err_orphan), 32'(m_err));

      disp_valid    = $urandom_range(0, 3) != 0;
      disp_rd       = 5'($urandom);
      disp_rd_fp    = 1'($urandom);
      fpu_complete  = prev_acc;
      fpu_result_1  = 16'($urandom);
      fpu_result_rd = $urandom;
      sflags        = 5'($urandom);
      csr_we        = $urandom_range(0, 15) == 0;
      csr_wdata     = 8'($urandom);
      gif.gpr_wr_ready = $urandom_range(0, 2) != 0;

      acc = disp_valid & exp_rdy;
      if (m_we) bcnt[m_wa]--;
      if (acc && disp_rd_fp) bcnt[disp_rd]++;
      if (gif.gpr_wr_ready && mgq.size() != 0)
        void'(mgq.pop_front());
      m_we = 1'b0;
      if (fpu_complete) begin
        if (mtq.size() != 0) begin
          t = mtq.pop_front();
          if (t.fp) begin
            m_we = 1'b1;
            m_wa = t.rd;
            m_wd = fpu_result_1;
          end else begin
            mgq.push_back('{t.rd, fpu_result_rd});
          end
        end else begin
          m_err = 1'b1;
        end
      end
      if (acc) mtq.push_back('{disp_rd, disp_rd_fp});
      if (csr_we) begin
        m_frm = csr_wdata[7:5];
        m_ff  = csr_wdata[4:0] | (m_pend ? sflags : 5'd0);
      end else if (m_pend) begin
        m_ff = m_ff | sflags;
      end
      m_pend   = fpu_complete;
      prev_acc = acc;
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
